// File: rtl/level_ctrl.sv
// level_ctrl -- map sequencer for a two-player level game.
//
// Walks the players through NUM_LEVELS maps. A start pulse on the title
// screen begins map 0. A hazard sends the level to a DEAD hold, after which
// the same map restarts. Both players in their doors sends it to a CLEAR
// hold, after which the next map starts, or WIN follows the last map.
// While a map is being played, the block also times the attempt in seconds
// and counts the diamonds collected.
//
// Optional build macro:
//   LEVEL_DIAMOND_GATE_EN - clearing also needs diamonds >= DIAMONDS_REQ.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   start         one-cycle start pulse (debounced)
//   p1_door/p2_door     player is inside its door (level)
//   p1_hazard/p2_hazard player touches a lethal river (level)
//   diamond_pulse one-cycle pulse per diamond collected
//   map_sel       active map index
//   map_en        map object-state enable (PLAY only)
//   map_rst       one-cycle map reinit pulse on every PLAY entry
//   state         FSM state code (TITLE=0 PLAY=1 DEAD=2 CLEAR=3 WIN=4)
//   level_time    seconds in current attempt, saturating at 999
//   diamonds      diamonds in current attempt, saturating at 15
module level_ctrl #(
  parameter int NUM_LEVELS    = 3,
  parameter int TICKS_PER_SEC = 100000000,
  parameter int HOLD_CYCLES   = 200000000,
  parameter int DIAMONDS_REQ  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       p1_door,
  input  logic       p2_door,
  input  logic       p1_hazard,
  input  logic       p2_hazard,
  input  logic       diamond_pulse,
  output logic [1:0] map_sel,
  output logic       map_en,
  output logic       map_rst,
  output logic [2:0] state,
  output logic [9:0] level_time,
  output logic [3:0] diamonds
);

  if (NUM_LEVELS < 1 || NUM_LEVELS > 4 || DIAMONDS_REQ < 0 || DIAMONDS_REQ > 15 ||
      TICKS_PER_SEC < 1 || HOLD_CYCLES < 1) begin : g_bad_param
    $error("level_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_TITLE = 3'd0,
    S_PLAY  = 3'd1,
    S_DEAD  = 3'd2,
    S_CLEAR = 3'd3,
    S_WIN   = 3'd4
  } state_t;

  localparam logic [31:0] TICK_LAST = 32'(TICKS_PER_SEC - 1);
  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);
  localparam logic [1:0]  LAST_SEL  = 2'(NUM_LEVELS - 1);
  localparam logic [9:0]  TIME_MAX  = 10'd999;
  localparam logic [3:0]  DIA_MAX   = 4'd15;

  state_t      cur, nxt;
  logic [1:0]  sel_nxt;
  logic [31:0] hold_cnt;
  logic [31:0] tick_cnt;
  logic        hold_done;
  logic        hazard;
  logic        clear_ok;
  logic        play_entry;
  logic        play_run;

  assign state     = cur;
  assign hold_done = (hold_cnt == HOLD_LAST);
  assign hazard    = p1_hazard | p2_hazard;
  // The first PLAY cycle is the map_rst cycle: counters stay cleared on it.
  assign play_run  = (cur == S_PLAY) && !map_rst;

`ifdef LEVEL_DIAMOND_GATE_EN
  assign clear_ok = p1_door & p2_door & (diamonds >= 4'(DIAMONDS_REQ));
`else
  assign clear_ok = p1_door & p2_door;
`endif

  always_comb begin
    nxt     = cur;
    sel_nxt = map_sel;
    case (cur)
      S_TITLE: if (start) begin
        nxt     = S_PLAY;
        sel_nxt = 2'd0;
      end
      S_PLAY: begin
        if (hazard)        nxt = S_DEAD;   // hazard beats a simultaneous clear
        else if (clear_ok) nxt = S_CLEAR;
      end
      S_DEAD: if (start || hold_done) nxt = S_PLAY;
      S_CLEAR: if (hold_done) begin
        if (map_sel == LAST_SEL) nxt = S_WIN;
        else begin
          nxt     = S_PLAY;
          sel_nxt = map_sel + 2'd1;
        end
      end
      S_WIN: if (start) begin
        nxt     = S_TITLE;
        sel_nxt = 2'd0;
      end
      default: begin
        nxt     = S_TITLE;
        sel_nxt = 2'd0;
      end
    endcase
  end

  assign play_entry = (nxt == S_PLAY) && (cur != S_PLAY);

  always_ff @(posedge clk) begin
    if (rst) begin
      cur        <= S_TITLE;
      map_sel    <= 2'd0;
      map_en     <= 1'b0;
      map_rst    <= 1'b0;
      hold_cnt   <= '0;
      tick_cnt   <= '0;
      level_time <= '0;
      diamonds   <= '0;
    end else begin
      cur     <= nxt;
      map_sel <= sel_nxt;
      map_en  <= (nxt == S_PLAY);
      map_rst <= play_entry;

      // Hold counter restarts on every state change, runs in DEAD/CLEAR.
      if ((cur == S_DEAD || cur == S_CLEAR) && nxt == cur) hold_cnt <= hold_cnt + 32'd1;
      else                                                 hold_cnt <= '0;

      if (play_entry) begin
        tick_cnt   <= '0;
        level_time <= '0;
        diamonds   <= '0;
      end else if (play_run) begin
        if (tick_cnt == TICK_LAST) begin
          tick_cnt <= '0;
          if (level_time != TIME_MAX) level_time <= level_time + 10'd1;
        end else begin
          tick_cnt <= tick_cnt + 32'd1;
        end
        if (diamond_pulse && diamonds != DIA_MAX) diamonds <= diamonds + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_level_ctrl.sv
module tb_level_ctrl;
  localparam int NUM  = 3;
  localparam int TPS  = 10;
  localparam int HOLD = 4;
  localparam int DREQ = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0, start = 1'b0;
  logic       p1_door = 1'b0, p2_door = 1'b0, p1_hazard = 1'b0, p2_hazard = 1'b0;
  logic       diamond_pulse = 1'b0;
  logic [1:0] map_sel;
  logic       map_en, map_rst;
  logic [2:0] state;
  logic [9:0] level_time;
  logic [3:0] diamonds;

  level_ctrl #(.NUM_LEVELS(NUM), .TICKS_PER_SEC(TPS), .HOLD_CYCLES(HOLD),
               .DIAMONDS_REQ(DREQ)) dut (
    .clk(clk), .rst(rst), .start(start),
    .p1_door(p1_door), .p2_door(p2_door),
    .p1_hazard(p1_hazard), .p2_hazard(p2_hazard),
    .diamond_pulse(diamond_pulse),
    .map_sel(map_sel), .map_en(map_en), .map_rst(map_rst),
    .state(state), .level_time(level_time), .diamonds(diamonds)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: tracks the game in terms of how long we have been in a
  // state and how many counted play cycles have elapsed; seconds follow by
  // division.
  localparam int TITLE = 0, PLAY = 1, DEAD = 2, CLEAR = 3, WIN = 4;
  int ms = 0, msel = 0, mk = 0, mcnt = 0, mdia = 0;
  bit mfirst = 0;
  bit chk_en = 0;

  always @(posedge clk) begin
    int ns, nsel;
    bit gate_ok;
    if (rst) begin
      ms = TITLE; msel = 0; mk = 0; mcnt = 0; mdia = 0; mfirst = 0;
      chk_en = 1;
    end else begin
      gate_ok = 1;
`ifdef LEVEL_DIAMOND_GATE_EN
      gate_ok = (mdia >= DREQ);
`endif
      ns = ms; nsel = msel;
      case (ms)
        TITLE: if (start) begin ns = PLAY; nsel = 0; end
        PLAY:  if (p1_hazard || p2_hazard) ns = DEAD;
               else if (p1_door && p2_door && gate_ok) ns = CLEAR;
        DEAD:  if (start || mk == HOLD - 1) ns = PLAY;
        CLEAR: if (mk == HOLD - 1) begin
                 if (msel == NUM - 1) ns = WIN;
                 else begin ns = PLAY; nsel = msel + 1; end
               end
        WIN:   if (start) begin ns = TITLE; nsel = 0; end
        default: ns = TITLE;
      endcase
      if (ms == PLAY && !mfirst) begin
        mcnt++;
        if (diamond_pulse && mdia < 15) mdia++;
      end
      mk = (ns == ms) ? mk + 1 : 0;
      mfirst = (ns == PLAY && ms != PLAY);
      if (mfirst) begin mcnt = 0; mdia = 0; end
      ms = ns; msel = nsel;
    end
  end

  always @(negedge clk) begin
    int secs;
    if (chk_en) begin
      secs = mcnt / TPS;
      if (secs > 999) secs = 999;
      check("state", 32'(state), 32'(ms));
      check("map_sel", 32'(map_sel), 32'(msel));
      check("map_en", 32'(map_en), 32'(ms == PLAY));
      check("map_rst", 32'(map_rst), 32'(mfirst));
      check("level_time", 32'(level_time), 32'(secs));
      check("diamonds", 32'(diamonds), 32'(mdia));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  initial begin
    // reset then start
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    check("rst_state", 32'(state), 0);
    check("rst_time", 32'(level_time), 0);
    pulse_start();
    check("start_state", 32'(state), 1);
    check("start_sel", 32'(map_sel), 0);
    check("start_map_rst", 32'(map_rst), 1);
    check("start_map_en", 32'(map_en), 1);
    cyc();
    check("map_rst_one_cycle", 32'(map_rst), 0);

    // timer: 25 edges after map_rst, 24 of them counted
    repeat (24) cyc();
    check("time_2s", 32'(level_time), 2);
    repeat (10500) cyc();
    check("time_sat", 32'(level_time), 999);

    // hazard wins over doors
    p1_door = 1'b1; p2_door = 1'b1; p2_hazard = 1'b1; cyc();
    p1_door = 1'b0; p2_door = 1'b0; p2_hazard = 1'b0;
    check("haz_dead", 32'(state), 2);
    check("dead_time_hold", 32'(level_time), 999);
    repeat (3) cyc();
    check("dead_still", 32'(state), 2);
    cyc();
    check("dead_replay", 32'(state), 1);
    check("dead_sel", 32'(map_sel), 0);
    check("dead_map_rst", 32'(map_rst), 1);
    check("dead_time0", 32'(level_time), 0);
    cyc();

    // clear through all levels
    for (int lvl = 0; lvl < NUM; lvl++) begin
`ifdef LEVEL_DIAMOND_GATE_EN
      diamond_pulse = 1'b1; cyc(); diamond_pulse = 1'b0;
`endif
      p1_door = 1'b1; p2_door = 1'b1; cyc();
      p1_door = 1'b0; p2_door = 1'b0;
      check("clear_state", 32'(state), 3);
      start = 1'b1; repeat (HOLD) cyc(); start = 1'b0;   // start ignored in CLEAR
      if (lvl < NUM - 1) begin
        check("next_play", 32'(state), 1);
        check("next_sel", 32'(map_sel), 32'(lvl + 1));
        cyc();
      end else begin
        check("win_state", 32'(state), 4);
      end
    end
    p1_door = 1'b1; p2_door = 1'b1; p1_hazard = 1'b1; cyc();
    p1_door = 1'b0; p2_door = 1'b0; p1_hazard = 1'b0;
    check("win_ignores", 32'(state), 4);
    pulse_start();
    check("title_state", 32'(state), 0);
    check("title_sel", 32'(map_sel), 0);

    // diamonds, optional gate, then reset mid-hold
    pulse_start(); cyc();
`ifdef LEVEL_DIAMOND_GATE_EN
    p1_door = 1'b1; p2_door = 1'b1; cyc();
    p1_door = 1'b0; p2_door = 1'b0;
    check("gate_blocks", 32'(state), 1);
`endif
    diamond_pulse = 1'b1; cyc();
    check("dia_one", 32'(diamonds), 1);
    repeat (19) cyc();
    diamond_pulse = 1'b0;
    check("dia_sat", 32'(diamonds), 15);
    p1_door = 1'b1; p2_door = 1'b1; cyc();
    p1_door = 1'b0; p2_door = 1'b0;
    check("clear_again", 32'(state), 3);
    cyc(); cyc();                       // hold count now 2
    rst = 1'b1; cyc(); rst = 1'b0;
    check("midhold_state", 32'(state), 0);
    check("midhold_sel", 32'(map_sel), 0);
    check("midhold_dia", 32'(diamonds), 0);
    cyc();
    check("midhold_stay", 32'(state), 0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 199) == 0);
      start         = ($urandom_range(0, 29) == 0);
      p1_door       = ($urandom_range(0, 2) == 0);
      p2_door       = ($urandom_range(0, 2) == 0);
      p1_hazard     = ($urandom_range(0, 39) == 0);
      p2_hazard     = ($urandom_range(0, 39) == 0);
      diamond_pulse = ($urandom_range(0, 3) == 0);
      cyc();
    end
    rst = 1'b0; start = 1'b0; p1_door = 1'b0; p2_door = 1'b0;
    p1_hazard = 1'b0; p2_hazard = 1'b0; diamond_pulse = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
